// File: rtl/x_div.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Define XDIV_SIGNED_EN for two's complement operands (truncating division); unsigned otherwise.
module x_div #(
  parameter int unsigned bus_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*bus_width-1:0] A,
  input  logic [bus_width-1:0]   B,
  output logic [2*bus_width-1:0] Q,
  output logic [bus_width-1:0]   R,
  output logic                   busy,
  output logic                   done,
  output logic                   dbz
);

  localparam int unsigned DW = 2 * bus_width;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB
  logic [DW-1:0]        dvd;
  logic [bus_width-1:0] dvs;
  logic [bus_width-1:0] prem;
  logic [CW-1:0]        cnt;
  logic                 dbz_pend;

  logic                 accept, last;
  logic [bus_width:0]   rem_sh;
  logic                 q_bit;
  logic [bus_width-1:0] diff, rem_nx;
  logic [DW-1:0]        quo_nx, a_mag, q_fin;
  logic [bus_width-1:0] b_mag, r_fin;

`ifdef XDIV_SIGNED_EN
  logic neg_q, neg_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A pending divide-by-zero result blocks acceptance so busy and done never overlap.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !dbz_pend) begin
          accept = 1'b1;
          if (B != '0) state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(DW - 1)) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rem_sh = {prem, dvd[DW-1]};
    q_bit  = (rem_sh >= {1'b0, dvs});
    // partial remainder stays below dvs, so the low W bits of the difference are exact
    diff   = rem_sh[bus_width-1:0] - dvs;
    rem_nx = q_bit ? diff : rem_sh[bus_width-1:0];
    quo_nx = {dvd[DW-2:0], q_bit};
`ifdef XDIV_SIGNED_EN
    a_mag  = A[DW-1] ? -A : A;
    b_mag  = B[bus_width-1] ? -B : B;
    q_fin  = neg_q ? -quo_nx : quo_nx;
    r_fin  = neg_r ? -rem_nx : rem_nx;
`else
    a_mag  = A;
    b_mag  = B;
    q_fin  = quo_nx;
    r_fin  = rem_nx;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dvs      <= '0;
      prem     <= '0;
      cnt      <= '0;
      dbz_pend <= 1'b0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
`ifdef XDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      dbz_pend <= 1'b0;
      if (accept) begin
        dvd  <= a_mag;
        dvs  <= b_mag;
        prem <= '0;
        cnt  <= '0;
`ifdef XDIV_SIGNED_EN
        neg_q <= A[DW-1] ^ B[bus_width-1];
        neg_r <= A[DW-1];
`endif
        if (B == '0) dbz_pend <= 1'b1;
        else         busy     <= 1'b1;
      end
      if (dbz_pend) begin
        Q    <= '1;
        R    <= '0;
        dbz  <= 1'b1;
        done <= 1'b1;
      end
      if (state == RUN) begin
        dvd  <= quo_nx;
        prem <= rem_nx;
        cnt  <= cnt + 1'b1;
        if (last) begin
          Q    <= q_fin;
          R    <= r_fin;
          dbz  <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
